apb_master_bridge: RTL and testbench

- APB requester (initiator) that drives the shared APB bus toward a completer such as the aligner core's register block.
- Converts a simple valid/ready command stream (addr, write flag, wdata) into APB SETUP/ACCESS phases.
- Returns a registered response (rdata, slverr) over a valid/ready response channel.
- Sits between the test/firmware-side sequencer logic and the APB completer; one outstanding transfer at a time.

---
 rtl/apb_master_pkg.sv | 10 +
 rtl/apb_master_bridge.sv | 95 +++++++++
 tb/tb_apb_master_bridge.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM state, default bus widths and response record for the APB requester bridge
package apb_master_pkg;
  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
  } apb_rsp_t;
endpackage

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB SETUP/ACCESS transfers, one outstanding at a time
// Optional ACCESS-phase watchdog compiled in with AY_APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);
  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  rsp_valid_q, rsp_valid_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  accept, done, consume, timeout;
`ifdef AY_APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_q, wait_d;
  always_comb wait_d = (state_q == SETUP) ? '0 : (state_q == ACCESS && !pready) ? wait_q + 1'b1 : wait_q;
  always_ff @(posedge clk) wait_q <= preset ? '0 : wait_d;
  assign timeout = (state_q == ACCESS) && !pready && (wait_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (preset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (pready || timeout) ? IDLE : ACCESS;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    accept       = cmd_valid && cmd_ready;
    done         = (state_q == ACCESS) && (pready || timeout);
    consume      = rsp_valid_q && rsp_ready;
    paddr_d      = accept ? cmd_addr : paddr_q;
    pwrite_d     = accept ? cmd_write : pwrite_q;
    pwdata_d     = accept ? (cmd_write ? cmd_wdata : '0) : pwdata_q;
    rsp_valid_d  = done ? 1'b1 : (consume ? 1'b0 : rsp_valid_q);
    // a watchdog abort reports an error with no data; pready in the same cycle wins
    rsp_d.rdata  = done ? ((pready && !pwrite_q) ? APB_DATA_WIDTH'(prdata) : '0) : (consume ? '0 : rsp_q.rdata);
    rsp_d.slverr = done ? (pready ? pslverr : 1'b1) : (consume ? 1'b0 : rsp_q.slverr);
  end
  always_comb begin
    psel       = state_q != IDLE;
    penable    = state_q == ACCESS;
    cmd_ready  = (state_q == IDLE) && !rsp_valid_q;
    pwrite     = pwrite_q;
    paddr      = paddr_q;
    pwdata     = pwdata_q;
    rsp_valid  = rsp_valid_q;
    rsp_rdata  = rsp_q.rdata[DATA_WIDTH-1:0];
    rsp_slverr = rsp_q.slverr;
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and randomized APB transfers checked against per-transfer expectations
module tb_apb_master_bridge;
  logic        clk = 1'b0;
  logic        preset, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_slverr;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [15:0] cmd_addr, paddr;
  logic [31:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  apb_master_bridge dut (
    .clk(clk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer: accept, SETUP, ACCESS with `waits` wait states, response held for `bp` cycles.
  task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] wd, input int waits,
                      input logic [31:0] rd, input logic err, input int bp);
    logic [31:0] exp_rd, exp_wd;
    exp_rd = w ? 32'h0 : rd;
    exp_wd = w ? wd : 32'h0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_wdata = $urandom; cmd_write = ~w;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    chk("setup_pwdata", pwdata, exp_wd);
    for (int k = 0; k <= waits; k++) begin
      step();
      pready  = (k == waits);
      prdata  = pready ? rd : $urandom;
      pslverr = pready ? err : 1'b1;
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, a);
      chk("access_pwdata", pwdata, exp_wd);
      chk("access_no_rsp", rsp_valid, 0);
    end
    step();
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_slverr", rsp_slverr, err);
    chk("rsp_psel_low", psel, 0);
    chk("rsp_penable_low", penable, 0);
    chk("rsp_cmd_ready_low", cmd_ready, 0);
    for (int k = 0; k < bp; k++) begin
      cmd_valid = 1'b1; cmd_addr = 16'($urandom);
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, exp_rd);
      chk("bp_rsp_slverr", rsp_slverr, err);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("consumed_valid", rsp_valid, 0);
    chk("consumed_rdata", rsp_rdata, 0);
    chk("consumed_slverr", rsp_slverr, 0);
    chk("consumed_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    step(); step();
    preset = 1'b0;
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_pwrite", pwrite, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_slverr", rsp_slverr, 0);
    chk("reset_cmd_ready", cmd_ready, 1);

    xfer(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0, 0);
    xfer(1'b0, 16'h0020, 32'h0, 3, 32'h12345678, 1'b0, 0);
    xfer(1'b0, 16'h00FF, 32'h0, 0, 32'hCAFEF00D, 1'b1, 0);
    xfer(1'b0, 16'h0030, 32'h0, 1, 32'h0BADBEEF, 1'b0, 5);
    xfer(1'b1, 16'h0034, 32'h11223344, 2, 32'h55555555, 1'b1, 0);

    for (int n = 0; n < 24; n++)
      xfer(1'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, 4)), $urandom,
           1'($urandom), int'($urandom_range(0, 3)));

    // reset in the middle of a waiting ACCESS drops the transfer
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("pre_reset_penable", penable, 1);
    preset = 1'b1;
    step();
    preset = 1'b0;
    chk("midreset_psel", psel, 0);
    chk("midreset_penable", penable, 0);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_paddr", paddr, 0);
    pready = 1'b1; prdata = 32'hFFFF0000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("postreset_no_rsp", rsp_valid, 0);
      chk("postreset_psel", psel, 0);
    end
    pready = 1'b0;

    // completer never ready
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0077;
    step();
    cmd_valid = 1'b0;
`ifdef AY_APB_MASTER_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      step();
      chk("to_wait_penable", penable, 1);
    end
    step();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_slverr", rsp_slverr, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
`else
    for (int k = 0; k < 40; k++) begin
      step();
      chk("stuck_penable", penable, 1);
      chk("stuck_no_rsp", rsp_valid, 0);
    end
    pready = 1'b1; prdata = 32'h600DF00D; pslverr = 1'b0;
    step();
    pready = 1'b0;
    chk("late_rsp_valid", rsp_valid, 1);
    chk("late_rsp_rdata", rsp_rdata, 32'h600DF00D);
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("final_cmd_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
